instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC loaded by reset.
REQ-002 Parameter: XLEN, 32, width of PC, addresses and instruction word.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pc_sel  input  2  next-PC select, sampled at accept: 00 sequential, 01 imm_target, 10 jalr_target, 11 treated as 00.
REQ-006 imm_target  input  XLEN  PC+imm target for branches and JAL.
REQ-007 jalr_target  input  XLEN  rs1+imm target for JALR.
REQ-008 inst_ready  input  1  consumer (decode/execute) accepts held instruction.
REQ-009 imem_ack  input  1  memory response strobe; imem_rdata valid in the same cycle.
REQ-010 imem_rdata  input  XLEN  instruction word from memory.
REQ-011 imem_req  output  1  fetch request.
REQ-012 imem_addr  output  XLEN  fetch address; always equals pc.
REQ-013 inst  output  XLEN  registered instruction word.
REQ-014 inst_valid  output  1  inst/pc are valid for the consumer.
REQ-015 pc  output  XLEN  address of the current instruction.
REQ-016 pc_plus4  output  XLEN  pc+4, the link value for JAL/JALR.
REQ-017 fault  output  1  sticky misaligned-target fault.
REQ-018 retired  output  32  count of accepted instructions.

Function
REQ-019 States SHALL be FETCH, HOLD and FAULT.
REQ-020 In FETCH, imem_req SHALL be 1 and imem_addr = pc, held stable until imem_ack.
REQ-021 In FETCH with imem_ack=1, the block SHALL register imem_rdata into inst and move to HOLD; inst_valid=1 from the next cycle.
REQ-022 Ack may arrive in the first request cycle, giving a minimum latency of 1 cycle from FETCH entry to inst_valid.
REQ-023 imem_ack SHALL be ignored in HOLD and FAULT.
REQ-024 In HOLD, imem_req=0; inst, pc and inst_valid SHALL stay stable while inst_ready=0.
REQ-025 Accept = HOLD & inst_ready; on accept, next_pc SHALL be pc+4 (sel 00/11), imm_target (01) or {jalr_target[XLEN-1:1],1'b0} (10).
REQ-026 On accept with next_pc[1:0]==00: pc<=next_pc, retired+=1, state->FETCH, inst_valid->0.
REQ-027 On accept with next_pc[1:0]!=00: pc unchanged, retired+=1, fault<=1, state->FAULT.
REQ-028 FAULT SHALL be terminal until rst, with imem_req=0 and inst_valid=0.
REQ-029 pc+4 and retired SHALL wrap modulo 2^XLEN and 2^32 without flagging.
REQ-030 pc_plus4 SHALL be combinational from pc.
REQ-031 No speculative or overlapping fetch: at most one outstanding request.

Reset
REQ-032 While rst=1: pc=RESET_PC, state=FETCH, imem_req=0, inst=0, inst_valid=0, fault=0, retired=0.
REQ-033 rst asserted mid-fetch or in HOLD SHALL abandon that instruction, and an ack in the reset cycle SHALL be dropped.
REQ-034 In the first cycle after rst deasserts, imem_req=1 and imem_addr=RESET_PC.

Structure
REQ-035 A shared package SHALL hold the state enum (FETCH/HOLD/FAULT) and the PC_SEL constants SEQ=2'b00, BR=2'b01, JALR=2'b10.
REQ-036 Next-PC selection and the alignment check SHALL be one combinational sub-module, next_pc_sel.

Verification
REQ-037 Reset, zero-wait ack, inst_ready=1, pc_sel=00 -> imem_addr 0,4,8; inst_valid every 2nd cycle; retired=3 after 3 accepts.
REQ-038 ack delayed 3 cycles, with imem_rdata=32'hDEAD_BEEF presented only on the ack cycle -> imem_addr stable for 4 cycles; inst=32'hDEAD_BEEF the next cycle.
REQ-039 HOLD with inst_ready=0 for 5 cycles while spurious acks arrive -> inst, pc and inst_valid unchanged, imem_req=0.
REQ-040 Accept at pc=0x10 with pc_sel=01, imm_target=0x40 -> next imem_addr=0x40; pc_sel=10, jalr_target=0x81 -> next imem_addr=0x80.
REQ-041 Accept with pc_sel=01, imm_target=0x42 -> fault=1, retired incremented, imem_req=0 forever; rst -> fault=0 and fetch resumes at RESET_PC.
REQ-042 rst asserted in a FETCH cycle coinciding with imem_ack -> inst_valid stays 0; first post-reset request is to RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state encoding and the next-PC select codes
// driven by the execute stage.
package instr_fetch_unit_pkg;

    localparam int unsigned STATE_W  = 2;
    localparam int unsigned PC_SEL_W = 2;

    typedef enum logic [STATE_W-1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } ifu_state_t;

    // Next-PC select codes; the unused code 2'b11 behaves as sequential.
    localparam logic [PC_SEL_W-1:0] PC_SEL_SEQ  = 2'b00;
    localparam logic [PC_SEL_W-1:0] PC_SEL_BR   = 2'b01;
    localparam logic [PC_SEL_W-1:0] PC_SEL_JALR = 2'b10;

endpackage : instr_fetch_unit_pkg

// File: rtl/next_pc_sel.sv
// Next-PC selection and target alignment check (purely combinational).
// Ports:
//   pc_plus4     in   sequential successor of the current pc
//   pc_sel       in   select code (SEQ / BR / JALR, 2'b11 = SEQ)
//   imm_target   in   pc+imm target for branches and JAL
//   jalr_target  in   rs1+imm target for JALR (bit 0 is discarded)
//   next_pc_c    out  selected next pc
//   misaligned_c out  selected next pc is not word aligned
module next_pc_sel
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]     pc_plus4,
    input  logic [PC_SEL_W-1:0] pc_sel,
    input  logic [XLEN-1:0]     imm_target,
    input  logic [XLEN-1:0]     jalr_target,
    output logic [XLEN-1:0]     next_pc_c,
    output logic                misaligned_c
);

    // Target mux; JALR clears bit 0 of the computed address.
    always_comb begin
        next_pc_c = pc_plus4;
        case (pc_sel)
            PC_SEL_BR:   next_pc_c = imm_target;
            PC_SEL_JALR: next_pc_c = jalr_target & ~XLEN'(1);
            default:     next_pc_c = pc_plus4;
        endcase
        misaligned_c = |next_pc_c[1:0];
    end

endmodule : next_pc_sel

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit.
// Fetches one word at pc, holds it until the consumer accepts it, then
// steps pc sequentially or to a branch/jump target. A misaligned target
// parks the unit in a sticky FAULT state until reset.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   pc_sel             next-pc select, sampled at accept
//   imm_target         branch / JAL target
//   jalr_target        JALR target
//   inst_ready         consumer accepts the held instruction
//   imem_ack           memory response strobe (imem_rdata valid same cycle)
//   imem_rdata         instruction word from memory
//   imem_req           fetch request
//   imem_addr          fetch address (always pc)
//   inst               registered instruction word
//   inst_valid         inst / pc valid for the consumer
//   pc                 address of the current instruction
//   pc_plus4           pc + 4 link value (combinational)
//   fault              sticky misaligned-target fault
//   retired            count of accepted instructions
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_SEL_W-1:0] pc_sel,
    input  logic [XLEN-1:0]     imm_target,
    input  logic [XLEN-1:0]     jalr_target,
    input  logic                inst_ready,
    input  logic                imem_ack,
    input  logic [XLEN-1:0]     imem_rdata,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    output logic [XLEN-1:0]     inst,
    output logic                inst_valid,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     pc_plus4,
    output logic                fault,
    output logic [31:0]         retired
);

    ifu_state_t      state;
    ifu_state_t      state_next;
    logic            load_inst;
    logic            accept;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;

    assign pc_plus4  = pc + XLEN'(4);
    assign imem_addr = pc;

    next_pc_sel #(
        .XLEN (XLEN)
    ) u_next_pc_sel (
        .pc_plus4     (pc_plus4),
        .pc_sel       (pc_sel),
        .imm_target   (imm_target),
        .jalr_target  (jalr_target),
        .next_pc_c    (next_pc),
        .misaligned_c (misaligned)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            FETCH:   if (imem_ack) state_next = HOLD;
            HOLD:    if (inst_ready) state_next = misaligned ? FAULT : FETCH;
            FAULT:   state_next = FAULT;
            default: state_next = FETCH;
        endcase
    end

    // Output / control decode. The request is masked by rst so that it is
    // low for every cycle reset is asserted, including the first one.
    always_comb begin
        imem_req  = 1'b0;
        load_inst = 1'b0;
        accept    = 1'b0;
        case (state)
            FETCH: begin
                imem_req  = ~rst;
                load_inst = imem_ack;
            end
            HOLD:    accept = inst_ready;
            default: ;
        endcase
    end

    // Datapath: captured instruction, pc, sticky fault, retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            inst       <= '0;
            inst_valid <= 1'b0;
            fault      <= 1'b0;
            retired    <= '0;
        end else begin
            if (load_inst) begin
                inst       <= imem_rdata;
                inst_valid <= 1'b1;
            end
            if (accept) begin
                inst_valid <= 1'b0;
                retired    <= retired + 32'd1;
                // A misaligned target keeps pc on the faulting instruction.
                if (misaligned) begin
                    fault <= 1'b1;
                end else begin
                    pc <= next_pc;
                end
            end
        end
    end

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pc_sel;
    logic [31:0] imm_target;
    logic [31:0] jalr_target;
    logic        inst_ready;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fault;
    logic [31:0] retired;

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_sel      (pc_sel),
        .imm_target  (imm_target),
        .jalr_target (jalr_target),
        .inst_ready  (inst_ready),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fault       (fault),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model: architectural pc, retire count and fault flag.
    logic [31:0] m_pc;
    logic [31:0] m_retired;
    logic        m_fault;

    function automatic logic [31:0] model_target(input logic [31:0] cur, input logic [1:0] sel,
                                                 input logic [31:0] imm, input logic [31:0] jalr);
        if (sel == 2'd1) return imm;
        if (sel == 2'd2) return jalr - (jalr % 2);
        return cur + 32'd4;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; imem_ack = 1'b0; inst_ready = 1'b0;
        tick; tick;
        vectors++; if (pc !== RESET_PC) begin errors++; $display("FAIL rst_pc got=%h exp=%h", pc, RESET_PC); end
        vectors++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_inst got=%h exp=0", inst); end
        vectors++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", inst_valid); end
        vectors++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault got=%b exp=0", fault); end
        vectors++; if (retired !== 32'h0) begin errors++; $display("FAIL rst_retired got=%0d exp=0", retired); end
        vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        rst = 1'b0;
        #1;
        vectors++; if (imem_req !== 1'b1) begin errors++; $display("FAIL post_rst_req got=%b exp=1", imem_req); end
        vectors++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL post_rst_addr got=%h exp=%h", imem_addr, RESET_PC); end
        m_pc = RESET_PC; m_retired = 32'h0; m_fault = 1'b0;
    endtask

    // One full instruction: lat wait cycles, ack with data, stall cycles in
    // HOLD (with spurious acks), then accept with the given select/targets.
    task automatic fetch_one(input int lat, input logic [31:0] data, input int stall,
                             input logic [1:0] sel, input logic [31:0] imm, input logic [31:0] jalr);
        logic [31:0] nxt;
        for (int i = 0; i <= lat; i++) begin
            vectors++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fetch_req got=%b exp=1", imem_req); end
            vectors++; if (imem_addr !== m_pc) begin errors++; $display("FAIL fetch_addr got=%h exp=%h", imem_addr, m_pc); end
            vectors++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL fetch_valid got=%b exp=0", inst_valid); end
            imem_ack   = (i == lat);
            imem_rdata = (i == lat) ? data : $urandom;
            tick;
        end
        imem_ack = 1'b0; imem_rdata = $urandom;
        for (int i = 0; i <= stall; i++) begin
            vectors++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got=%b exp=1", inst_valid); end
            vectors++; if (inst !== data) begin errors++; $display("FAIL hold_inst got=%h exp=%h", inst, data); end
            vectors++; if (pc !== m_pc) begin errors++; $display("FAIL hold_pc got=%h exp=%h", pc, m_pc); end
            vectors++; if (pc_plus4 !== m_pc + 32'd4) begin errors++; $display("FAIL pc_plus4 got=%h exp=%h", pc_plus4, m_pc + 32'd4); end
            vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req got=%b exp=0", imem_req); end
            if (i < stall) begin
                imem_ack = 1'($urandom % 2); imem_rdata = $urandom;
                tick;
            end
        end
        imem_ack = 1'b0;
        inst_ready = 1'b1; pc_sel = sel; imm_target = imm; jalr_target = jalr;
        tick;
        inst_ready = 1'b0; pc_sel = 2'($urandom); imm_target = $urandom; jalr_target = $urandom;
        nxt = model_target(m_pc, sel, imm, jalr);
        m_retired = m_retired + 32'd1;
        if (nxt % 4 != 0) m_fault = 1'b1;
        else m_pc = nxt;
        vectors++; if (retired !== m_retired) begin errors++; $display("FAIL acc_retired got=%0d exp=%0d", retired, m_retired); end
        vectors++; if (fault !== m_fault) begin errors++; $display("FAIL acc_fault got=%b exp=%b", fault, m_fault); end
        vectors++; if (pc !== m_pc) begin errors++; $display("FAIL acc_pc got=%h exp=%h", pc, m_pc); end
        vectors++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL acc_valid got=%b exp=0", inst_valid); end
        vectors++; if (imem_req !== !m_fault) begin errors++; $display("FAIL acc_req got=%b exp=%b", imem_req, !m_fault); end
    endtask

    task automatic check_fault_parked(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            imem_ack = 1'($urandom % 2); inst_ready = 1'($urandom % 2); imem_rdata = $urandom;
            tick;
            vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fault_req got=%b exp=0", imem_req); end
            vectors++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL fault_valid got=%b exp=0", inst_valid); end
            vectors++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_sticky got=%b exp=1", fault); end
            vectors++; if (retired !== m_retired) begin errors++; $display("FAIL fault_retired got=%0d exp=%0d", retired, m_retired); end
        end
        imem_ack = 1'b0; inst_ready = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
    endtask

    task automatic test_sequential;
        do_reset;
        for (int k = 0; k < 3; k++) fetch_one(0, $urandom, 0, 2'b00, $urandom, $urandom);
        vectors++; if (retired !== 32'd3) begin errors++; $display("FAIL seq_retired got=%0d exp=3", retired); end
        vectors++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL seq_addr got=%h exp=0000000c", imem_addr); end
    endtask

    task automatic test_delayed_ack;
        fetch_one(3, 32'hDEAD_BEEF, 0, 2'b11, $urandom, $urandom);
    endtask

    task automatic test_hold_stall;
        fetch_one(1, $urandom, 5, 2'b00, $urandom, $urandom);
    endtask

    task automatic test_branch;
        do_reset;
        for (int k = 0; k < 4; k++) fetch_one(0, $urandom, 0, 2'b00, 32'h0, 32'h0);
        vectors++; if (pc !== 32'h10) begin errors++; $display("FAIL br_start_pc got=%h exp=00000010", pc); end
        fetch_one(0, $urandom, 0, 2'b01, 32'h40, $urandom);
        vectors++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL br_addr got=%h exp=00000040", imem_addr); end
        fetch_one(1, $urandom, 1, 2'b10, $urandom, 32'h81);
        vectors++; if (imem_addr !== 32'h80) begin errors++; $display("FAIL jalr_addr got=%h exp=00000080", imem_addr); end
    endtask

    task automatic test_fault;
        fetch_one(0, $urandom, 0, 2'b01, 32'h42, $urandom);
        vectors++; if (fault !== 1'b1) begin errors++; $display("FAIL br_fault got=%b exp=1", fault); end
        check_fault_parked(5);
        do_reset;
        fetch_one(0, $urandom, 0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic test_wrap;
        do_reset;
        fetch_one(0, $urandom, 0, 2'b01, 32'hFFFF_FFFC, $urandom);
        fetch_one(0, $urandom, 0, 2'b00, $urandom, $urandom);
        vectors++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=00000000", pc); end
        vectors++; if (fault !== 1'b0) begin errors++; $display("FAIL wrap_fault got=%b exp=0", fault); end
    endtask

    task automatic test_reset_during_fetch;
        do_reset;
        fetch_one(0, $urandom, 0, 2'b01, 32'h100, $urandom);
        // Reset coinciding with an ack: the word must be dropped.
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        tick;
        vectors++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_ack_valid got=%b exp=0", inst_valid); end
        vectors++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_ack_inst got=%h exp=0", inst); end
        rst = 1'b0; imem_ack = 1'b0;
        #1;
        vectors++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_ack_req got=%b exp=1", imem_req); end
        vectors++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL rst_ack_addr got=%h exp=%h", imem_addr, RESET_PC); end
        // Reset while holding: the instruction is abandoned, not retired.
        imem_ack = 1'b1; imem_rdata = $urandom;
        tick;
        imem_ack = 1'b0;
        vectors++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL pre_hold_valid got=%b exp=1", inst_valid); end
        rst = 1'b1; inst_ready = 1'b1; pc_sel = 2'b01; imm_target = 32'h200;
        tick;
        vectors++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid got=%b exp=0", inst_valid); end
        vectors++; if (retired !== 32'h0) begin errors++; $display("FAIL rst_hold_retired got=%0d exp=0", retired); end
        vectors++; if (pc !== RESET_PC) begin errors++; $display("FAIL rst_hold_pc got=%h exp=%h", pc, RESET_PC); end
        inst_ready = 1'b0;
        do_reset;
    endtask

    task automatic test_random;
        logic [31:0] imm;
        logic [31:0] jalr;
        do_reset;
        for (int k = 0; k < 40; k++) begin
            imm  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) imm = imm | 32'h2;
            jalr = $urandom & 32'hFFFF_FFFD;
            if ($urandom_range(0, 9) == 0) jalr = jalr | 32'h2;
            fetch_one($urandom_range(0, 3), $urandom, $urandom_range(0, 3), 2'($urandom), imm, jalr);
            if (m_fault) begin
                check_fault_parked(2);
                do_reset;
            end
        end
    endtask

    initial begin
        rst = 1'b1; pc_sel = 2'b00; imm_target = '0; jalr_target = '0;
        inst_ready = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        m_pc = RESET_PC; m_retired = '0; m_fault = 1'b0;
        test_reset;
        test_sequential;
        test_delayed_ack;
        test_hold_stall;
        test_branch;
        test_fault;
        test_wrap;
        test_reset_during_fetch;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_instr_fetch_unit
